chunked_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor with an internal accumulator. It processes the operands CHUNK bits per clock, LSB chunk first, and registers the carry between chunks. Valid/ready handshakes sit on both the operand and result sides. It supersedes the fixed 8-bit combinational ripple adder in the arithmetic datapath wherever operand width or area makes a one-cycle carry chain undesirable.

---
 rtl/chunked_addsub_if.sv | 31 +++
 rtl/chunked_addsub.sv | 126 ++++++++++++
 tb/tb_chunked_addsub.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/chunked_addsub_if.sv
// Operand/result bus for chunked_addsub.
// Handshake rule, both sides: a transfer happens on a rising clk edge where
// valid and ready are both high; the producer holds its data stable while
// valid is high and ready is low.
interface chunked_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             sub;
    logic             acc_mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    logic [WIDTH-1:0] acc;

    modport master (
        output in_valid, x, y, sub, acc_mode, acc_clr, out_ready,
        input  in_ready, out_valid, s, c, v, acc
    );

    modport slave (
        input  in_valid, x, y, sub, acc_mode, acc_clr, out_ready,
        output in_ready, out_valid, s, c, v, acc
    );
endinterface

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor with accumulator. Operands are summed CHUNK
// bits per clock, LSB chunk first, with the carry registered between chunks.
// WIDTH must be a multiple of CHUNK; CHUNK == WIDTH gives a single RUN cycle.
module chunked_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    chunked_addsub_if.slave    bus,
    output logic [1:0]         o_dbg_state
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_c;
    logic             r_v;
    logic [KW-1:0]    r_k;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_chunk_sum;
    logic             w_carry_into_msb;
    logic             w_last;
    logic             w_accept;
    logic             w_out_hs;

    // Current chunk of each operand and its sum with the registered carry.
    assign w_a_chunk   = r_a[r_k*CHUNK +: CHUNK];
    assign w_b_chunk   = r_b[r_k*CHUNK +: CHUNK];
    assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    // Carry into the top bit of the chunk, recovered from its sum bit.
    assign w_carry_into_msb = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_chunk_sum[CHUNK-1];
    assign w_last   = (r_k == KW'(N - 1));
    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_out_hs = (r_state == S_DONE) && bus.out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state; handshake outputs depend on state only.
    always_comb begin
        w_next_state  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (w_last) w_next_state = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand latch and chunk-serial datapath. Subtraction is A + ~B + 1,
    // with the +1 entering as the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_k     <= '0;
        end else begin
            if (w_accept) begin
                r_a     <= bus.acc_mode ? r_acc : bus.x;
                r_b     <= bus.sub ? ~bus.y : bus.y;
                r_carry <= bus.sub;
                r_k     <= '0;
            end else if (r_state == S_RUN) begin
                r_s[r_k*CHUNK +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
                r_carry <= w_chunk_sum[CHUNK];
                r_k     <= r_k + KW'(1);
                if (w_last) begin
                    r_c <= w_chunk_sum[CHUNK];
                    r_v <= w_carry_into_msb ^ w_chunk_sum[CHUNK];
                end
            end
        end
    end

    // Accumulator: clear has priority over capturing the delivered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (bus.acc_clr) begin
            r_acc <= '0;
        end else if (w_out_hs) begin
            r_acc <= r_s;
        end
    end

    assign bus.s       = r_s;
    assign bus.c       = r_c;
    assign bus.v       = r_v;
    assign bus.acc     = r_acc;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_chunked_addsub.sv
// Directed bench for chunked_addsub (WIDTH=8, CHUNK=2, four chunk cycles).
module tb_chunked_addsub;
    localparam int WIDTH = 8;
    localparam int CHUNK = 2;
    localparam int N     = WIDTH / CHUNK;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         checks;
    int         failures;

    // Expected {s, c, v} per result, oldest first.
    logic [WIDTH+1:0] exp_q[$];

    chunked_addsub_if #(.WIDTH(WIDTH)) bus ();

    chunked_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake pops and compares one expected result.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {bus.s, bus.c, bus.v}, 32'hdead);
            end else begin
                check("result_scv", {bus.s, bus.c, bus.v}, exp_q.pop_front());
            end
        end
    end

    // Present operands and hold them until the accept edge has passed.
    task automatic accept_only(input logic [7:0] xv, input logic [7:0] yv,
                               input logic sb, input logic am);
        int tries;
        bus.in_valid = 1'b1;
        bus.x        = xv;
        bus.y        = yv;
        bus.sub      = sb;
        bus.acc_mode = am;
        tries = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && tries < 40) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 40) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.x        = $urandom_range(0, 255);
        bus.y        = $urandom_range(0, 255);
        bus.sub      = 1'b0;
        bus.acc_mode = 1'b0;
    endtask

    // Issue one operation with its expected result; return once out_valid is seen,
    // checking the accept-to-valid latency along the way.
    task automatic issue(input string name, input logic [7:0] xv, input logic [7:0] yv,
                         input logic sb, input logic am,
                         input logic [7:0] es, input logic ec, input logic ev);
        int lat;
        exp_q.push_back({es, ec, ev});
        accept_only(xv, yv, sb, am);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, lat, N);
    endtask

    // Let the handshake edge pass (out_ready assumed high).
    task automatic finish_hs();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.x        = '0;
        bus.y        = '0;
        bus.sub      = 1'b0;
        bus.acc_mode = 1'b0;
        bus.acc_clr  = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state.
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_scv", {bus.s, bus.c, bus.v}, 0);
        check("rst_acc", bus.acc, 0);
        check("rst_state", dbg_state, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Add / subtract vectors with hand-computed results.
        issue("add_nc", 8'd25, 8'd37, 1'b0, 1'b0, 8'd62, 1'b0, 1'b0);
        finish_hs();
        issue("add_c", 8'd200, 8'd100, 1'b0, 1'b0, 8'd44, 1'b1, 1'b0);
        finish_hs();
        issue("add_ov", 8'd100, 8'd100, 1'b0, 1'b0, 8'd200, 1'b0, 1'b1);
        finish_hs();
        issue("sub_pos", 8'd37, 8'd25, 1'b1, 1'b0, 8'd12, 1'b1, 1'b0);
        finish_hs();
        issue("sub_neg", 8'd25, 8'd37, 1'b1, 1'b0, 8'd244, 1'b0, 1'b0);
        finish_hs();
        issue("sub_ov", 8'h80, 8'd1, 1'b1, 1'b0, 8'h7f, 1'b1, 1'b1);
        finish_hs();
        issue("add_wrap", 8'hff, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        finish_hs();
        issue("sub_zero", 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        finish_hs();
        check("in_ready_after_hs", bus.in_ready, 1);
        check("acc_follows_s", bus.acc, 8'h00);

        // Accumulate: clear, then +10, +20, -5 with A taken from acc.
        bus.acc_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.acc_clr = 1'b0;
        check("acc_clr_idle", bus.acc, 0);
        issue("acc1", 8'hee, 8'd10, 1'b0, 1'b1, 8'd10, 1'b0, 1'b0);
        finish_hs();
        check("acc_after1", bus.acc, 10);
        issue("acc2", 8'h00, 8'd20, 1'b0, 1'b1, 8'd30, 1'b0, 1'b0);
        finish_hs();
        check("acc_after2", bus.acc, 30);
        issue("acc3", 8'h55, 8'd5, 1'b1, 1'b1, 8'd25, 1'b1, 1'b0);
        finish_hs();
        check("acc_after3", bus.acc, 25);

        // Clear on the handshake edge wins over capturing s (which would be 32).
        issue("acc4", 8'h00, 8'd7, 1'b0, 1'b1, 8'd32, 1'b0, 1'b0);
        bus.acc_clr = 1'b1;
        finish_hs();
        bus.acc_clr = 1'b0;
        check("acc_clr_on_hs", bus.acc, 0);

        // Backpressure: hold DONE for 10 cycles while offering new operands.
        bus.out_ready = 1'b0;
        issue("bp", 8'd25, 8'd37, 1'b0, 1'b0, 8'd62, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.x        = 8'd1;
        bus.y        = 8'd2;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_scv", {bus.s, bus.c, bus.v}, {8'd62, 1'b0, 1'b0});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        finish_hs();
        check("bp_release_in_ready", bus.in_ready, 1);
        check("bp_release_out_valid", bus.out_valid, 0);
        check("bp_acc", bus.acc, 62);

        // Reset during RUN chunk 2: outputs return to reset values at once.
        accept_only(8'd50, 8'd60, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst_state", dbg_state, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_scv", {bus.s, bus.c, bus.v}, 0);
        check("midrst_acc", bus.acc, 0);
        check("midrst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue("post_rst", 8'd1, 8'd1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0);
        finish_hs();

        // Drain: no result may be outstanding or extra.
        repeat (8) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
